// File: rtl/ex_div_pkg.sv
// Shared widths, state encoding and handshake constants for the ex_div divider.
package ex_div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [5:0] DIV_ITERATIONS = 6'd32;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface ex_div_if;
  import ex_div_pkg::*;

  logic                      signed_div_i;
  logic [REG_BUS-1:0]        opdata1_i;
  logic [REG_BUS-1:0]        opdata2_i;
  logic                      start_i;
  logic                      annul_i;
  logic [DOUBLE_REG_BUS-1:0] result_o;
  logic                      ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Build option: define DIV_SIGNED_EN to enable the signed path; otherwise all divisions are unsigned.
//
// state      | meaning
// DIV_FREE   | idle, waiting for an accepted request
// DIV_BYZERO | divisor was zero, result forced to 0
// DIV_ON     | iterating; iter_cnt counts down the remaining quotient bits
// DIV_END    | result presented until start_i drops
module ex_div
  import ex_div_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave div
);

  div_state_e                state_q, state_d;
  logic [5:0]                iter_cnt_q, iter_cnt_d;
  logic [64:0]               dividend_q, dividend_d;
  logic [REG_BUS-1:0]        divisor_q, divisor_d;
  logic [DOUBLE_REG_BUS-1:0] result_q, result_d;
  logic                      ready_q, ready_d;

  logic [32:0]               diff;
  logic [REG_BUS-1:0]        quot, rem;
  logic [REG_BUS-1:0]        op1_abs, op2_abs;
  logic                      div_unused;

`ifdef DIV_SIGNED_EN
  logic op1_neg_q, op1_neg_d;
  logic q_neg_q, q_neg_d;

  assign div_unused = dividend_q[32];
`else
  assign div_unused = ^{dividend_q[32], div.signed_div_i};
`endif

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    ready_d    = ready_q;

    diff    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    op1_abs = div.opdata1_i;
    op2_abs = div.opdata2_i;
    quot    = dividend_q[31:0];
    rem     = dividend_q[64:33];

`ifdef DIV_SIGNED_EN
    op1_neg_d = op1_neg_q;
    q_neg_d   = q_neg_q;
    if (div.signed_div_i && div.opdata1_i[31]) op1_abs = ~div.opdata1_i + 32'd1;
    if (div.signed_div_i && div.opdata2_i[31]) op2_abs = ~div.opdata2_i + 32'd1;
    if (q_neg_q)   quot = ~dividend_q[31:0] + 32'd1;
    if (op1_neg_q) rem  = ~dividend_q[64:33] + 32'd1;
`endif

    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (div.start_i == DIV_START && !div.annul_i) begin
          state_d    = (div.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          iter_cnt_d = DIV_ITERATIONS;
          divisor_d  = op2_abs;
          dividend_d = {32'b0, op1_abs, 1'b0};
`ifdef DIV_SIGNED_EN
          op1_neg_d  = div.signed_div_i & div.opdata1_i[31];
          q_neg_d    = div.signed_div_i & (div.opdata1_i[31] ^ div.opdata2_i[31]);
`endif
        end
      end
      // ready_o comes from DIV_END, so a zero divisor reports one edge after leaving here
      DIV_BYZERO: begin
        state_d  = DIV_END;
        result_d = '0;
      end
      DIV_ON: begin
        if (div.annul_i) begin
          state_d    = DIV_FREE;
          ready_d    = DIV_RESULT_NOT_READY;
          iter_cnt_d = '0;
        end else if (iter_cnt_q != '0) begin
          dividend_d = diff[32] ? {dividend_q[63:0], 1'b0}
                                : {diff[31:0], dividend_q[31:0], 1'b1};
          iter_cnt_d = iter_cnt_q - 6'd1;
        end else begin
          result_d = {rem, quot};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        if (div.start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else begin
          ready_d  = DIV_RESULT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      iter_cnt_q <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
`ifdef DIV_SIGNED_EN
      op1_neg_q  <= 1'b0;
      q_neg_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
`ifdef DIV_SIGNED_EN
      op1_neg_q  <= op1_neg_d;
      q_neg_q    <= q_neg_d;
`endif
    end
  end

  assign div.result_o = result_q;
  assign div.ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: scoreboard of expected results, checked when ready_o rises.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_div_if dif ();

  ex_div dut (
    .clk (clk),
    .rst (rst),
    .div (dif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
`endif
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  // Issue one request, wait for ready, compare latency/result, hold, then release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int exp_lat, input bit scramble,
                        input string tag);
    int lat;
    bit seen;
    logic [63:0] want;
    @(negedge clk);
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.signed_div_i = sgn;
    dif.start_i      = 1'b1;
    sb_q.push_back(exp);
    lat  = -1;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (scramble) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = 1'($urandom_range(0, 1));
      end
      if (dif.ready_o) seen = 1'b1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    want = sb_q.pop_front();
    chk({tag, "_result"}, dif.result_o, want);
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, {dif.result_o[62:0], dif.ready_o}, {want[62:0], 1'b1});
    dif.start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_release"}, {63'd0, dif.ready_o} | dif.result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    int lat;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;

    #1;
    chk("reset_outputs", {63'd0, dif.ready_o} | dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0, "udiv_100_7");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33, 1'b0, "udiv_max_1");
    do_div(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 33, 1'b0, "udiv_small");
`ifdef DIV_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, "sdiv_m7_2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 1'b0, "sdiv_7_m2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, 1'b0, "sdiv_ovf");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 33, 1'b0, "divu_m7_2");
`else
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'd1, 32'h7FFF_FFFC}, 33, 1'b0, "nosign_m7_2");
`endif
    do_div(32'd5, 32'd0, 1'b0, 64'd0, 2, 1'b0, "div_by_zero");
    do_div(32'd123456789, 32'd1000, 1'b0, {32'd789, 32'd123456}, 33, 1'b1, "stable_ops");

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = $urandom_range(1, 32'hFFFF);
      s = 1'($urandom_range(0, 1));
      if (i == 3) b = $urandom | 32'h8000_0000;
      do_div(a, b, s, model(a, b, s), 33, 1'b0, "rand");
    end

    // annul at cycle 10 of ON
    @(negedge clk);
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    dif.start_i   = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(negedge clk);
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);

    // start together with annul in FREE must not be accepted
    dif.start_i = 1'b1;
    dif.annul_i = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen = 1'b1;
    end
    chk("start_annul_ignored", 64'(seen), 64'd0);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;

    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0, "after_annul");

    // async reset mid-ON
    @(negedge clk);
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_on", {63'd0, dif.ready_o} | dif.result_o, 64'd0);
    @(negedge clk);
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen = 1'b1;
    end
    chk("rst_no_partial", 64'(seen), 64'd0);
    do_div(32'd1, 32'd1, 1'b0, {32'd0, 32'd1}, 33, 1'b0, "after_reset");

    // async reset while a result is presented
    @(negedge clk);
    dif.opdata1_i = 32'd20;
    dif.opdata2_i = 32'd6;
    dif.start_i   = 1'b1;
    sb_q.push_back({32'd2, 32'd3});
    lat = 0;
    while (!dif.ready_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("end_result", dif.result_o, sb_q.pop_front());
    #2 rst = 1'b1;
    #1 chk("rst_in_end", {63'd0, dif.ready_o} | dif.result_o, 64'd0);
    @(negedge clk);
    dif.start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
